// File: rtl/sha3_256_scheduler_if.sv
// rtl/sha3_256_scheduler_if.sv - requester, core and consumer signals of the SHA3-256 scheduler
interface sha3_256_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             a_req;
    logic [63:0]      a_in;
    logic             a_in_ready;
    logic             a_is_last;
    logic [3:0]       a_byte_num;
    logic             a_grant;
    logic             a_buffer_full;

    logic             b_req;
    logic [63:0]      b_in;
    logic             b_in_ready;
    logic             b_is_last;
    logic [3:0]       b_byte_num;
    logic             b_grant;
    logic             b_buffer_full;

    logic             core_reset;
    logic [63:0]      core_in;
    logic             core_in_ready;
    logic             core_is_last;
    logic [3:0]       core_byte_num;
    logic             core_buffer_full;
    logic [255:0]     core_out;
    logic             core_out_ready;

    logic [255:0]     hash_out;
    logic             hash_valid;
    logic             hash_id;
    logic             hash_ack;
    logic [CNT_W-1:0] msg_words;

    // slave is the scheduler; master is everything around it
    modport slave (
        input  a_req, a_in, a_in_ready, a_is_last, a_byte_num,
        output a_grant, a_buffer_full,
        input  b_req, b_in, b_in_ready, b_is_last, b_byte_num,
        output b_grant, b_buffer_full,
        output core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
        input  core_buffer_full, core_out, core_out_ready,
        output hash_out, hash_valid, hash_id, msg_words,
        input  hash_ack
    );

    modport master (
        output a_req, a_in, a_in_ready, a_is_last, a_byte_num,
        input  a_grant, a_buffer_full,
        output b_req, b_in, b_in_ready, b_is_last, b_byte_num,
        input  b_grant, b_buffer_full,
        input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
        output core_buffer_full, core_out, core_out_ready,
        input  hash_out, hash_valid, hash_id, msg_words,
        output hash_ack
    );
endinterface

// File: rtl/sha3_256_scheduler.sv
// rtl/sha3_256_scheduler.sv - round-robin sharing of one SHA3-256 core between two requesters
module sha3_256_scheduler #(
    parameter int CLR_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sha3_256_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FEED, WAIT_HASH, DELIVER, CLEAR} state_e;

    localparam logic [3:0]       CLR_LOAD = 4'(CLR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [3:0]       clr_cnt_q, clr_cnt_d;
    logic             a_grant_q, a_grant_d;
    logic             b_grant_q, b_grant_d;
    logic             last_b_q, last_b_d;
    logic [255:0]     hash_out_q, hash_out_d;
    logic             hash_valid_q, hash_valid_d;
    logic             hash_id_q, hash_id_d;
    logic [CNT_W-1:0] msg_words_q, msg_words_d;

    logic [63:0]      core_in;
    logic             core_in_ready;
    logic             core_is_last;
    logic [3:0]       core_byte_num;
    logic             a_buffer_full;
    logic             b_buffer_full;
    logic             sel_ready;
    logic             sel_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= CLR_LOAD;
            a_grant_q    <= 1'b0;
            b_grant_q    <= 1'b0;
            last_b_q     <= 1'b1;
            hash_out_q   <= '0;
            hash_valid_q <= 1'b0;
            hash_id_q    <= 1'b0;
            msg_words_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            a_grant_q    <= a_grant_d;
            b_grant_q    <= b_grant_d;
            last_b_q     <= last_b_d;
            hash_out_q   <= hash_out_d;
            hash_valid_q <= hash_valid_d;
            hash_id_q    <= hash_id_d;
            msg_words_q  <= msg_words_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        a_grant_d     = a_grant_q;
        b_grant_d     = b_grant_q;
        last_b_d      = last_b_q;
        hash_out_d    = hash_out_q;
        hash_valid_d  = hash_valid_q;
        hash_id_d     = hash_id_q;
        msg_words_d   = msg_words_q;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        a_buffer_full = 1'b1;
        b_buffer_full = 1'b1;
        sel_ready     = b_grant_q ? bus.b_in_ready : bus.a_in_ready;
        sel_last      = b_grant_q ? bus.b_is_last  : bus.a_is_last;

        // the padder latches is_last unconditionally, so it is gated by the stall too
        if (state_q == FEED) begin
            core_in       = b_grant_q ? bus.b_in       : bus.a_in;
            core_byte_num = b_grant_q ? bus.b_byte_num : bus.a_byte_num;
            core_in_ready = sel_ready & ~bus.core_buffer_full;
            core_is_last  = sel_last & sel_ready & ~bus.core_buffer_full;
            if (b_grant_q) b_buffer_full = bus.core_buffer_full;
            else           a_buffer_full = bus.core_buffer_full;
        end

        case (state_q)
            IDLE: begin
                if (bus.a_req && (!bus.b_req || last_b_q)) begin
                    a_grant_d   = 1'b1;
                    last_b_d    = 1'b0;
                    msg_words_d = '0;
                    state_d     = FEED;
                end else if (bus.b_req) begin
                    b_grant_d   = 1'b1;
                    last_b_d    = 1'b1;
                    msg_words_d = '0;
                    state_d     = FEED;
                end
            end
            FEED: begin
                if (core_in_ready) begin
                    if (msg_words_q != CNT_MAX) msg_words_d = msg_words_q + CNT_W'(1);
                    if (core_is_last) begin
                        a_grant_d = 1'b0;
                        b_grant_d = 1'b0;
                        state_d   = WAIT_HASH;
                    end
                end
            end
            WAIT_HASH: begin
                if (bus.core_out_ready) begin
                    hash_out_d   = bus.core_out;
                    hash_id_d    = last_b_q;
                    hash_valid_d = 1'b1;
                    state_d      = DELIVER;
                end
            end
            DELIVER: begin
                if (bus.hash_ack) begin
                    hash_valid_d = 1'b0;
                    clr_cnt_d    = CLR_LOAD;
                    state_d      = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q <= 4'd1) state_d = IDLE;
                else                   clr_cnt_d = clr_cnt_q - 4'd1;
            end
            default: begin
                clr_cnt_d = CLR_LOAD;
                state_d   = CLEAR;
            end
        endcase
    end

    assign bus.a_grant       = a_grant_q;
    assign bus.b_grant       = b_grant_q;
    assign bus.a_buffer_full = a_buffer_full;
    assign bus.b_buffer_full = b_buffer_full;
    assign bus.core_reset    = reset | (state_q == CLEAR);
    assign bus.core_in       = core_in;
    assign bus.core_in_ready = core_in_ready;
    assign bus.core_is_last  = core_is_last;
    assign bus.core_byte_num = core_byte_num;
    assign bus.hash_out      = hash_out_q;
    assign bus.hash_valid    = hash_valid_q;
    assign bus.hash_id       = hash_id_q;
    assign bus.msg_words     = msg_words_q;
endmodule

// File: tb/tb_sha3_256_scheduler.sv
// tb/tb_sha3_256_scheduler.sv - directed vectors for sha3_256_scheduler
module tb_sha3_256_scheduler;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    sha3_256_scheduler_if #(.CNT_W(16)) m ();
    sha3_256_scheduler_if #(.CNT_W(2))  m2 ();

    sha3_256_scheduler #(.CLR_CYCLES(2), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(m.slave));
    sha3_256_scheduler #(.CLR_CYCLES(2), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(m2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           who;
        bit           other_req;
        int           nwords;
        logic [3:0]   bn;
        int           ack_dly;
        logic [255:0] digest;
        logic         exp_id;
        logic [15:0]  exp_words;
    } msg_vec_t;

    msg_vec_t vecs [4];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic grant_of(input bit who);
        return who ? m.b_grant : m.a_grant;
    endfunction

    function automatic logic bf_of(input bit who);
        return who ? m.b_buffer_full : m.a_buffer_full;
    endfunction

    function automatic logic [63:0] word_of(input bit who, input int tag, input int i);
        return {16'(who), 16'(tag), 32'h0000_1000 + 32'(i)};
    endfunction

    task automatic set_req(input bit who, input logic r);
        if (who) m.b_req = r;
        else     m.a_req = r;
    endtask

    task automatic set_word(input bit who, input logic [63:0] d, input logic rdy, input logic last, input logic [3:0] bn);
        if (who) begin
            m.b_in = d; m.b_in_ready = rdy; m.b_is_last = last; m.b_byte_num = bn;
        end else begin
            m.a_in = d; m.a_in_ready = rdy; m.a_is_last = last; m.a_byte_num = bn;
        end
    endtask

    task automatic wait_grant(input bit who);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (grant_of(who)) begin
                got = 1'b1;
                break;
            end
        end
        chk("grant_seen", 256'(got), 256'd1);
        chk("other_grant_low", 256'(grant_of(!who)), 256'd0);
    endtask

    task automatic finish_hash(input bit who, input logic [255:0] dig, input int ack_dly);
        int n;
        repeat (2) @(negedge clk);
        m.core_out = dig;
        m.core_out_ready = 1'b1;
        #1 chk("wait_hash_no_valid", 256'(m.hash_valid), 256'd0);
        @(negedge clk); #1;
        chk("hash_valid_set", 256'(m.hash_valid), 256'd1);
        chk("hash_out", m.hash_out, dig);
        chk("hash_id", 256'(m.hash_id), 256'(who));
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk); #1;
            chk("deliver_hold", {m.hash_valid, m.a_grant, m.b_grant}, 256'b100);
            chk("deliver_hash_stable", m.hash_out, dig);
        end
        m.hash_ack = 1'b1;
        @(negedge clk);
        m.hash_ack = 1'b0;
        m.core_out_ready = 1'b0;
        #1 chk("hash_valid_dropped", 256'(m.hash_valid), 256'd0);
        n = 0;
        while (m.core_reset && n < 20) begin
            n++;
            @(negedge clk); #1;
        end
        chk("core_reset_cycles", 256'(n), 256'd2);
    endtask

    task automatic run_msg(input msg_vec_t v, input int tag);
        set_req(v.who, 1'b1);
        set_req(!v.who, v.other_req);
        wait_grant(v.who);
        for (int i = 0; i < v.nwords; i++) begin
            set_word(v.who, word_of(v.who, tag, i), 1'b1, (i == v.nwords - 1), v.bn);
            #1;
            chk("core_in_ready", 256'(m.core_in_ready), 256'd1);
            chk("core_in", 256'(m.core_in), 256'(word_of(v.who, tag, i)));
            chk("core_is_last", 256'(m.core_is_last), 256'(i == v.nwords - 1));
            chk("core_byte_num", 256'(m.core_byte_num), 256'(v.bn));
            @(negedge clk);
        end
        set_word(v.who, 64'd0, 1'b0, 1'b0, 4'd0);
        set_req(v.who, 1'b0);
        #1;
        chk("grant_dropped", 256'(grant_of(v.who)), 256'd0);
        chk("msg_words", 256'(m.msg_words), 256'(v.exp_words));
        chk("buffer_full_after", 256'(bf_of(v.who)), 256'd1);
        finish_hash(v.exp_id, v.digest, v.ack_dly);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        vecs[0] = '{who: 1'b0, other_req: 1'b1, nwords: 3, bn: 4'd5, ack_dly: 0,
                    digest: {4{64'hA5A5_0000_1111_0003}}, exp_id: 1'b0, exp_words: 16'd3};
        vecs[1] = '{who: 1'b1, other_req: 1'b1, nwords: 2, bn: 4'd3, ack_dly: 10,
                    digest: {4{64'hB0B0_2222_3333_0002}}, exp_id: 1'b1, exp_words: 16'd2};
        vecs[2] = '{who: 1'b0, other_req: 1'b1, nwords: 1, bn: 4'd0, ack_dly: 1,
                    digest: {4{64'hC3C3_4444_5555_0001}}, exp_id: 1'b0, exp_words: 16'd1};
        vecs[3] = '{who: 1'b1, other_req: 1'b0, nwords: 4, bn: 4'd7, ack_dly: 0,
                    digest: {4{64'hD2D2_6666_7777_0004}}, exp_id: 1'b1, exp_words: 16'd4};

        reset = 1'b1;
        m.a_req = 0; m.a_in = 0; m.a_in_ready = 0; m.a_is_last = 0; m.a_byte_num = 0;
        m.b_req = 0; m.b_in = 0; m.b_in_ready = 0; m.b_is_last = 0; m.b_byte_num = 0;
        m.core_buffer_full = 0; m.core_out = 0; m.core_out_ready = 0; m.hash_ack = 0;
        m2.a_req = 0; m2.a_in = 0; m2.a_in_ready = 0; m2.a_is_last = 0; m2.a_byte_num = 0;
        m2.b_req = 0; m2.b_in = 0; m2.b_in_ready = 0; m2.b_is_last = 0; m2.b_byte_num = 0;
        m2.core_buffer_full = 0; m2.core_out = 0; m2.core_out_ready = 0; m2.hash_ack = 0;

        repeat (3) @(negedge clk);
        m.a_req = 1'b1;
        m.b_req = 1'b1;
        #1;
        chk("rst_core_reset", 256'(m.core_reset), 256'd1);
        chk("rst_grants", {m.a_grant, m.b_grant}, 256'd0);
        chk("rst_hash", {m.hash_valid, m.hash_id, m.hash_out}, 256'd0);
        chk("rst_msg_words", 256'(m.msg_words), 256'd0);
        chk("rst_buffer_full", {m.a_buffer_full, m.b_buffer_full}, 256'b11);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n = 0;
        while (m.core_reset && n < 20) begin
            chk("clear_no_grant", {m.a_grant, m.b_grant}, 256'd0);
            n++;
            @(negedge clk); #1;
        end
        chk("rst_clear_cycles", 256'(n), 256'd2);

        for (int t = 0; t < 4; t++) run_msg(vecs[t], t);

        // last word arrives while the padder is stalled
        m.a_req = 1'b1;
        wait_grant(1'b0);
        set_word(1'b0, 64'h1111, 1'b1, 1'b0, 4'd6);
        #1 chk("bf_word0_accept", 256'(m.core_in_ready), 256'd1);
        @(negedge clk);
        m.core_buffer_full = 1'b1;
        set_word(1'b0, 64'h2222, 1'b1, 1'b1, 4'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bf_stall_strobes", {m.core_in_ready, m.core_is_last}, 256'd0);
            chk("bf_stall_full", {m.a_buffer_full, m.b_buffer_full}, 256'b11);
            @(negedge clk);
        end
        m.core_buffer_full = 1'b0;
        #1;
        chk("bf_release_strobes", {m.core_in_ready, m.core_is_last}, 256'b11);
        chk("bf_release_full", {m.a_buffer_full, m.b_buffer_full}, 256'b01);
        @(negedge clk);
        set_word(1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
        m.a_req = 1'b0;
        #1;
        chk("bf_done", {m.a_grant, m.core_is_last}, 256'd0);
        chk("bf_msg_words", 256'(m.msg_words), 256'd2);
        finish_hash(1'b0, {4{64'hE1E1_8888_9999_0002}}, 0);

        // reset in the middle of a message
        m.a_req = 1'b1;
        wait_grant(1'b0);
        for (int i = 0; i < 2; i++) begin
            set_word(1'b0, word_of(1'b0, 9, i), 1'b1, 1'b0, 4'd1);
            @(negedge clk);
        end
        set_word(1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
        m.a_req = 1'b0;
        reset = 1'b1;
        #1 chk("midrst_core_reset_now", 256'(m.core_reset), 256'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_grants", {m.a_grant, m.b_grant}, 256'd0);
        chk("midrst_hash_valid", 256'(m.hash_valid), 256'd0);
        chk("midrst_msg_words", 256'(m.msg_words), 256'd0);
        n = 0;
        while (m.core_reset && n < 20) begin
            n++;
            @(negedge clk); #1;
        end
        chk("midrst_clear_cycles", 256'(n), 256'd2);
        run_msg('{who: 1'b0, other_req: 1'b0, nwords: 3, bn: 4'd2, ack_dly: 0,
                  digest: {4{64'hF0F0_AAAA_BBBB_0003}}, exp_id: 1'b0, exp_words: 16'd3}, 10);

        // 2-bit counter saturates at 3
        m2.a_req = 1'b1;
        n = 0;
        while (!m2.a_grant && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("sat_grant", 256'(m2.a_grant), 256'd1);
        for (int i = 0; i < 5; i++) begin
            m2.a_in = 64'(i);
            m2.a_in_ready = 1'b1;
            m2.a_is_last = (i == 4);
            @(negedge clk);
            if (i == 1) #1 chk("sat_two_words", 256'(m2.msg_words), 256'd2);
        end
        m2.a_in_ready = 1'b0;
        m2.a_is_last = 1'b0;
        m2.a_req = 1'b0;
        #1 chk("sat_msg_words", 256'(m2.msg_words), 256'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
